// File: rtl/dist_fifo_m_pkg.sv
// Shared constants for the distributed-RAM FWFT FIFO.
// Storage output-register configuration used by the FIFO's RAM.
package dist_fifo_m_pkg;
  localparam string RAM_OUT_REG = "YES";
endpackage

// File: rtl/dist_fifo_m_ram.sv
// Simple dual-port distributed RAM, one write port,
// one read port with optional output register.
module sdp_distributed_ram_m
  import dist_fifo_m_pkg::*;
#(
  parameter int    ADDR_WIDTH = 4,
  parameter int    WORD_WIDTH = 32,
  parameter string OUTPUT_REG = RAM_OUT_REG
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WORD_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= data_in;
  end

  // Contents and output register are deliberately not reset.
  generate
    if (OUTPUT_REG == "YES") begin : g_reg
      always_ff @(posedge clk) begin
        data_out <= mem[raddr];
      end
    end else begin : g_comb
      assign data_out = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/dist_fifo_m.sv
// First-word-fall-through FIFO in front of a
// registered-output distributed RAM.
module dist_fifo_m
  import dist_fifo_m_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] P1 = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] C1 = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH:0]   vis_count;
  logic                  push;
  logic                  pop;
  logic                  push_d;

  assign s_ready = ~rst & (count != FULL);
  assign push    = s_valid & s_ready & ~clr;
  assign m_valid = (vis_count != '0);
  assign pop     = m_valid & m_ready;
  // Look one entry ahead on a pop so the next word is
  // registered in time for a back-to-back pop.
  assign raddr   = pop ? rptr + P1 : rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      vis_count <= '0;
      push_d    <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      vis_count <= '0;
      push_d    <= 1'b0;
    end else begin
      push_d <= push;
      if (push) wptr <= wptr + P1;
      if (pop)  rptr <= rptr + P1;
      unique case ({push, pop})
        2'b10:   count <= count + C1;
        2'b01:   count <= count - C1;
        default: count <= count;
      endcase
      // A word becomes readable one cycle after its write lands.
      unique case ({push_d, pop})
        2'b10:   vis_count <= vis_count + C1;
        2'b01:   vis_count <= vis_count - C1;
        default: vis_count <= vis_count;
      endcase
    end
  end

  sdp_distributed_ram_m #(ADDR_WIDTH, WORD_WIDTH, RAM_OUT_REG) u_ram (
    .clk      (clk),
    .we       (push),
    .waddr    (wptr),
    .data_in  (s_data),
    .raddr    (raddr),
    .data_out (m_data)
  );

endmodule
